// File: rtl/painel_pkg.sv
// painel_pkg: shared mode, direction and FSM state constants for the display scroll register.
package painel_pkg;
  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/painel_prescaler.sv
// painel_prescaler: reloadable down-counter; clk/clr_n, load+value reload, en counts down to 0 and holds, zero flags cnt==0.
module painel_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) cnt <= '0;
    else if (load) cnt <= value;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/painel_scroll_reg.sv
// painel_scroll_reg: STEP-wise shift/rotate display register with timed auto-scroll; ports: load/d, mode/dir/fill, step, start/n_steps/div/stop -> q, busy, tick, done.
module painel_scroll_reg
  import painel_pkg::*;
#(
  parameter int WIDTH = 28,
  parameter int STEP  = 7,
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [STEP-1:0]  fill,
  input  logic             step,
  input  logic             start,
  input  logic [CNT_W-1:0] n_steps,
  input  logic [DIV_W-1:0] div,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tick,
  output logic             done
);
  state_t state, state_nx;
  logic [DIV_W-1:0] div_eff, div_in, reload;
  logic [CNT_W-1:0] rem;
  logic [STEP-1:0] ins;
  logic [WIDTH-1:0] stepped;
  logic pre_zero, start_ok, run_step, apply, last;
  always_comb begin
    div_in   = div == '0 ? DIV_W'(1) : div;
    start_ok = state == ST_IDLE && start && !load;
    run_step = state == ST_RUN && pre_zero && !load && !stop;
    apply    = run_step || (state == ST_IDLE && step && !load && !start);
    last     = run_step && rem == CNT_W'(1);
    reload   = (start_ok ? div_in : div_eff) - 1'b1;
    // rotate re-inserts the digit falling off the far end; shift inserts fill
    ins      = mode == MODE_ROT ? (dir == DIR_RIGHT ? q[STEP-1:0] : q[WIDTH-1 -: STEP]) : fill;
    stepped  = (mode == MODE_HOLD || mode == MODE_RSVD) ? q :
               dir == DIR_LEFT ? WIDTH'({q, ins}) : WIDTH'({ins, q} >> STEP);
    state_nx = state;
    state_nx = (load || (state == ST_RUN && stop) || last) ? ST_IDLE : start_ok ? ST_RUN : state;
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) state <= ST_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      q       <= '0;
      tick    <= 1'b0;
      done    <= 1'b0;
      rem     <= '0;
      div_eff <= '0;
    end else begin
      q       <= load ? d : apply ? stepped : q;
      tick    <= apply;
      done    <= last;
      rem     <= start_ok ? n_steps : (run_step && rem != '0) ? rem - 1'b1 : rem;
      div_eff <= start_ok ? div_in : div_eff;
    end
  painel_prescaler #(.W(DIV_W)) u_pre (
    .clk   (clk),
    .clr_n (clr_n),
    .load  (start_ok || run_step),
    .en    (state == ST_RUN),
    .value (reload),
    .zero  (pre_zero)
  );
  assign busy = state == ST_RUN;
endmodule

// File: tb/tb_painel_scroll_reg.sv
// tb_painel_scroll_reg: randomized self-checking bench against a digit-level reference model.
module tb_painel_scroll_reg;
  localparam int W = 28, S = 7, DW = 16, CW = 8;
  logic clk = 0, clr_n = 0, load = 0, step = 0, start = 0, stop = 0, dir = 0;
  logic busy, tick, done;
  logic [1:0] mode = 0;
  logic [W-1:0] d = 0, q, qm = 0;
  logic [S-1:0] fill = 0;
  logic [DW-1:0] div = 0;
  logic [CW-1:0] n_steps = 0;
  int checks = 0, errors = 0;

  painel_scroll_reg dut (
    .clk(clk), .clr_n(clr_n), .load(load), .d(d), .mode(mode), .dir(dir), .fill(fill),
    .step(step), .start(start), .n_steps(n_steps), .div(div), .stop(stop),
    .q(q), .busy(busy), .tick(tick), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_step(input logic [W-1:0] v, input logic [1:0] m,
                                              input logic dr, input logic [S-1:0] f);
    logic [S-1:0] dg[4];
    logic [S-1:0] nd[4];
    logic [S-1:0] ins;
    for (int i = 0; i < 4; i++) dg[i] = v[S*i +: S];
    if (m == 2'b00 || m == 2'b11) return v;
    ins = (m == 2'b10) ? (dr ? dg[0] : dg[3]) : f;
    for (int i = 0; i < 4; i++) begin
      if (dr) nd[i] = (i == 3) ? ins : dg[(i + 1) % 4];
      else    nd[i] = (i == 0) ? ins : dg[(i + 3) % 4];
    end
    return {nd[3], nd[2], nd[1], nd[0]};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1; d = v;
    cyc;
    load = 0;
    qm = v;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (q !== '0) begin errors++; $display("FAIL reset_q got %h want 0", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (tick !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b want 00", tick, done); end
    #10 clr_n = 1;
    cyc;
    do_load(28'h1234567);
    mode = 2'b10; dir = 0; div = 2; n_steps = 5; start = 1;
    cyc;
    start = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", busy); end
    cyc; cyc;
    #2 clr_n = 0;
    #1;
    checks++; if (q !== '0) begin errors++; $display("FAIL async_reset_q got %h want 0", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b want 0", busy); end
    @(posedge clk);
    #2 clr_n = 1;
    cyc; cyc; cyc;
    checks++; if (busy !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL post_reset_idle got busy %b tick %b want 0 0", busy, tick); end
    qm = '0;
    mode = 2'b00; step = 1;
    cyc;
    step = 0;
    checks++; if (tick !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_step got tick %b busy %b want 1 0", tick, busy); end
  endtask

  task automatic test_fill_shift;
    do_load(28'h0ABCDEF);
    mode = 2'b01; dir = 0; fill = 7'h7F; step = 1;
    cyc;
    step = 0;
    checks++; if (q !== 28'h5E6F7FF) begin errors++; $display("FAIL fill_left_q got %h want 5e6f7ff", q); end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL fill_left_tick got %b want 1", tick); end
    cyc;
    checks++; if (tick !== 1'b0 || q !== 28'h5E6F7FF) begin errors++; $display("FAIL fill_left_after got tick %b q %h want 0 5e6f7ff", tick, q); end
    qm = 28'h5E6F7FF;
  endtask

  task automatic test_rotate_right;
    do_load(28'h0000001);
    mode = 2'b10; dir = 1; step = 1;
    cyc;
    checks++; if (q !== 28'h0200000) begin errors++; $display("FAIL rot_right1 got %h want 0200000", q); end
    cyc; cyc; cyc;
    step = 0;
    checks++; if (q !== 28'h0000001 || tick !== 1'b1) begin errors++; $display("FAIL rot_right4 got %h tick %b want 0000001 1", q, tick); end
    qm = 28'h0000001;
    cyc;
  endtask

  task automatic test_auto_run;
    logic et;
    do_load(28'h1234567);
    mode = 2'b10; dir = 0; div = 3; n_steps = 4; start = 1;
    cyc;
    start = 0; div = 1; n_steps = 1;
    for (int e = 1; e <= 12; e++) begin
      cyc;
      et = (e % 3 == 0);
      if (et) qm = model_step(qm, mode, dir, fill);
      checks++; if (tick !== et) begin errors++; $display("FAIL auto_tick e%0d got %b want %b", e, tick, et); end
      checks++; if (done !== (e == 12) || busy !== (e < 12)) begin errors++; $display("FAIL auto_done_busy e%0d got %b%b want %b%b", e, done, busy, e == 12, e < 12); end
      checks++; if (q !== qm) begin errors++; $display("FAIL auto_q e%0d got %h want %h", e, q, qm); end
    end
    checks++; if (q !== 28'h1234567) begin errors++; $display("FAIL auto_final got %h want 1234567", q); end
    cyc;
    checks++; if (tick !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL auto_quiet got %b%b%b want 000", tick, done, busy); end
  endtask

  task automatic test_abort;
    logic [W-1:0] dv;
    mode = 2'b01; dir = 1; fill = S'($urandom);
    do_load(W'($urandom));
    div = 0; n_steps = 0; start = 1;
    cyc;
    start = 0;
    for (int t = 1; t <= 10; t++) begin
      cyc;
      qm = model_step(qm, mode, dir, fill);
      checks++; if (tick !== 1'b1 || busy !== 1'b1 || q !== qm) begin errors++; $display("FAIL cont_tick t%0d got tick %b busy %b q %h want 1 1 %h", t, tick, busy, q, qm); end
    end
    stop = 1;
    cyc;
    stop = 0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL stop_flags got busy %b done %b tick %b want 000", busy, done, tick); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (q !== qm) begin errors++; $display("FAIL stop_frozen got %h want %h", q, qm); end
      cyc;
    end
    start = 1;
    cyc;
    start = 0;
    for (int t = 1; t <= 5; t++) begin
      cyc;
      qm = model_step(qm, mode, dir, fill);
      checks++; if (tick !== 1'b1 || q !== qm) begin errors++; $display("FAIL cont2_tick t%0d got tick %b q %h want 1 %h", t, tick, q, qm); end
    end
    dv = W'($urandom);
    do_load(dv);
    checks++; if (q !== dv || done !== 1'b0 || busy !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL load_abort got q %h done %b busy %b tick %b want %h 0 0 0", q, done, busy, tick, dv); end
    cyc;
    checks++; if (q !== dv || tick !== 1'b0) begin errors++; $display("FAIL load_abort_after got %h tick %b want %h 0", q, tick, dv); end
  endtask

  task automatic test_back_to_back;
    logic et;
    mode = 2'b10; dir = 1;
    do_load(W'($urandom));
    div = 2; n_steps = 3; start = 1;
    cyc;
    step = 1;
    for (int e = 1; e <= 6; e++) begin
      cyc;
      et = (e % 2 == 0);
      if (et) qm = model_step(qm, mode, dir, fill);
      checks++; if (tick !== et || done !== (e == 6) || q !== qm) begin errors++; $display("FAIL ignored e%0d got tick %b done %b q %h want %b %b %h", e, tick, done, q, et, e == 6, qm); end
    end
    div = 2; n_steps = 2; step = 0;
    cyc;
    start = 0;
    checks++; if (busy !== 1'b1 || tick !== 1'b0) begin errors++; $display("FAIL b2b_start got busy %b tick %b want 1 0", busy, tick); end
    for (int e = 1; e <= 4; e++) begin
      cyc;
      et = (e % 2 == 0);
      if (et) qm = model_step(qm, mode, dir, fill);
      checks++; if (tick !== et || done !== (e == 4) || busy !== (e < 4) || q !== qm) begin errors++; $display("FAIL b2b e%0d got %b%b%b q %h want %b%b%b %h", e, tick, done, busy, q, et, e == 4, e < 4, qm); end
    end
  endtask

  task automatic test_random;
    int de, n;
    logic et;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 2) == 0) do_load(W'($urandom));
        mode = 2'($urandom); dir = 1'($urandom); fill = S'($urandom); step = 1;
        cyc;
        step = 0;
        qm = model_step(qm, mode, dir, fill);
        checks++; if (q !== qm || tick !== 1'b1) begin errors++; $display("FAIL rnd_manual it%0d got %h tick %b want %h 1", it, q, tick, qm); end
      end else begin
        div = DW'($urandom_range(0, 4)); n = $urandom_range(1, 5); n_steps = CW'(n);
        de = (div == 0) ? 1 : int'(div);
        start = 1;
        cyc;
        start = 0;
        for (int e = 1; e <= de * n; e++) begin
          mode = 2'($urandom); dir = 1'($urandom); fill = S'($urandom);
          cyc;
          et = (e % de == 0);
          if (et) qm = model_step(qm, mode, dir, fill);
          checks++; if (tick !== et || done !== (e == de * n) || q !== qm) begin errors++; $display("FAIL rnd_run it%0d e%0d got %b%b q %h want %b%b %h", it, e, tick, done, q, et, e == de * n, qm); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_run_end it%0d busy %b want 0", it, busy); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_fill_shift;
    test_rotate_right;
    test_auto_run;
    test_abort;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/painel_scroll_reg.md
# painel_scroll_reg

Parametrised universal shift register with a built-in timed scroll engine for the electronic display panel. It holds a WIDTH-bit display word, for example four 7-bit segment digits, and supports parallel load, hold, fill-shift and rotate in either direction, always by STEP bits (one digit) per step. Steps come from a single manual pulse or from an auto-scroll run of n_steps steps spaced div cycles apart. The block sits between the message source and the segment drivers.

## Interface
- WIDTH, 28, register width; must be ≥ STEP
- STEP, 7, bits moved per step (one digit)
- DIV_W, 16, width of the step-period input and the prescaler
- CNT_W, 8, width of the step-count input and the remaining-step counter
- clk  in  1  rising-edge clock
- clr_n  in  1  reset, asynchronous, active-low
- load  in  1  parallel load of d
- d  in  WIDTH  parallel data
- mode  in  2  00 hold, 01 shift with fill, 10 rotate, 11 hold (reserved)
- dir  in  1  0 = toward MSB (left), 1 = toward LSB (right)
- fill  in  STEP  symbol inserted by a fill-shift
- step  in  1  manual single step (IDLE only)
- start  in  1  begin an auto-scroll run
- n_steps  in  CNT_W  run length; 0 = continuous until stop
- div  in  DIV_W  cycles between steps; 0 is treated as 1
- stop  in  1  abort the run
- q  out  WIDTH  display word
- busy  out  1  high while in RUN
- tick  out  1  one-cycle pulse on every applied step
- done  out  1  one-cycle pulse when a run completes its count

## Operation
- Step function, evaluated with the live mode/dir/fill at the step edge:
  - Left shift: q ← {q[WIDTH-STEP-1:0], fill}
  - Right shift: q ← {fill, q[WIDTH-1:STEP]}
  - Left rotate: q ← {q[WIDTH-STEP-1:0], q[WIDTH-1:WIDTH-STEP]}
  - Right rotate: q ← {q[STEP-1:0], q[WIDTH-1:STEP]}
  - Hold (00 or 11): q unchanged, but tick still pulses.
- States:
  - IDLE: step applies one step. start latches div_eff = max(div, 1) and n_steps, loads prescaler = div_eff − 1 and remaining = n_steps, then enters RUN.
  - RUN: the prescaler counts down. At 0 a step is applied, tick pulses and the prescaler reloads to div_eff − 1. If remaining = 1, the FSM returns to IDLE and done pulses. If remaining = 0, the run is continuous and never completes. Otherwise remaining decrements.
- Priority per edge: load > stop > start > step > run step.
  - load in RUN: q ← d and the FSM returns to IDLE; no tick, no done.
  - stop in RUN: FSM returns to IDLE, q keeps its current value; no done.
  - start and step are ignored in RUN.
  - stop in IDLE has no effect.
- div and n_steps are sampled only at start. Changing them mid-run has no effect.

## Timing
- Reset: clr_n low asynchronously forces q = 0, busy = 0, tick = 0, done = 0, state IDLE, and both counters to 0. This holds even mid-run.
- load or manual step: q updates at the same edge; tick is high the following cycle.
- start accepted at edge k: busy = 1 after edge k. Steps land at edges k + div_eff·i, for i = 1..n_steps.
- Final step edge: q updates, tick = 1, done = 1 and busy = 0, all registered together for one cycle.
- A new start is accepted on the cycle busy is low, so back-to-back runs are possible.
- tick and done are registered, single-cycle outputs. No combinational input-to-output paths.

## Structure
- Shared package painel_pkg holds:
  - mode constants MODE_HOLD, MODE_SHIFT, MODE_ROT, MODE_RSVD
  - DIR_LEFT, DIR_RIGHT
  - FSM state encoding ST_IDLE, ST_RUN
- One sub-module, painel_prescaler: a reloadable DIV_W-bit down-counter with load, reload value and a zero flag. The step function and FSM stay in the top level.

## Test plan
- Reset mid-run: start (div = 2, n_steps = 5), then pull clr_n low between edges → q = 0, busy = 0 immediately, before the next edge. Release → state is IDLE.
- Fill-shift left: load d = 28'h0ABCDEF, mode = 01, dir = 0, fill = 7'h7F, one step → q = 28'h5E6F7FF, tick for one cycle.
- Rotate right: load 28'h0000001, mode = 10, dir = 1.
  - After one step → q = 28'h0200000.
  - After four steps → q = 28'h0000001.
- Auto-run: load 28'h1234567, rotate left, div = 3, n_steps = 4, start at edge 0 → tick at edges 3, 6, 9, 12. done and busy fall at edge 12. q = 28'h1234567.
- Abort cases: continuous run (n_steps = 0, div = 0) gives a tick every cycle; after 10 ticks assert stop → busy = 0, no done, q frozen. Repeat the run with load at tick 5 → q = d, no done.
- Ignored inputs: start and step asserted while busy → tick timing unchanged; a second start on the cycle after done → a new run begins.
